ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and memory address.
REQ-002 Parameter INST_W, default 32, width of instruction word.
REQ-003 Parameter ICACHE_LINES, default 8, power of two, cache entries (used only with ICACHE_EN).
REQ-004 Port clk  input  1  sole clock, rising edge; one clock only.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port i_PCREG_pc  input  ADDR_W  fetch address from PC register.
REQ-007 Port i_PCREG_valid  input  1  i_PCREG_pc is a real fetch request.
REQ-008 Port o_PCREG_wait  output  1  PC register must hold its outputs this cycle.
REQ-009 Port o_MEM_req  output  1  instruction memory read request.
REQ-010 Port o_MEM_addr  output  ADDR_W  memory read address.
REQ-011 Port i_MEM_ack  input  1  memory data valid this cycle.
REQ-012 Port i_MEM_data  input  INST_W  returned instruction word.
REQ-013 Port o_IDSUE_inst  output  INST_W  fetched instruction to issue stage.
REQ-014 Port o_IDSUE_pc  output  ADDR_W  PC of o_IDSUE_inst.
REQ-015 Port o_IDSUE_valid  output  1  o_IDSUE_inst/o_IDSUE_pc are valid.
REQ-016 Port i_IDSUE_stall  input  1  issue stage cannot accept an instruction.
REQ-017 Port i_ROB_flush  input  1  ROB redirect; discard all in-flight fetch state.

Function
REQ-018 States: IDLE (empty), REQ (miss outstanding), HOLD (instruction presented), DROP (flushed miss awaiting ack).
REQ-019 o_PCREG_wait = (state==REQ) | (state==DROP) | (state==HOLD & i_IDSUE_stall); combinational.
REQ-020 Accept condition: i_PCREG_valid & ~o_PCREG_wait & ~i_ROB_flush; the PC is captured on that edge.
REQ-021 Accept with cache hit -> HOLD next cycle, o_IDSUE_inst from cache; latency 1 cycle.
REQ-022 Accept with miss -> REQ next cycle; o_MEM_req=1, o_MEM_addr=captured PC, both held stable until i_MEM_ack.
REQ-023 REQ & i_MEM_ack -> HOLD next cycle with registered i_MEM_data and captured PC; o_MEM_req drops the same edge.
REQ-024 o_IDSUE_valid=1 exactly in HOLD; outputs held unchanged while i_IDSUE_stall=1.
REQ-025 HOLD & ~i_IDSUE_stall: instruction consumed; with an accept the same edge, back-to-back to HOLD/REQ; else IDLE.
REQ-026 i_ROB_flush in REQ without ack -> DROP; o_MEM_req stays high until ack; ack in DROP -> IDLE, data discarded.
REQ-027 i_ROB_flush in HOLD or IDLE -> IDLE; o_IDSUE_valid low next cycle; flush beats any accept the same cycle.
REQ-028 i_ROB_flush with i_MEM_ack the same cycle in REQ -> IDLE, data not forwarded.
REQ-029 i_MEM_ack in IDLE or HOLD is ignored.

Reset
REQ-030 rst asserted asynchronously forces state=IDLE, o_MEM_req=0, o_IDSUE_valid=0; o_MEM_addr, o_IDSUE_pc and o_IDSUE_inst = 0.
REQ-031 Reset mid-miss abandons the request; a late ack after release is ignored per REQ-029.
REQ-032 Reset clears all cache valid bits.

Configuration
REQ-033 Macro ICACHE_EN defined: direct-mapped cache, ICACHE_LINES words, index = PC[log2(ICACHE_LINES)+1:2], tag = upper PC bits, line valid bit.
REQ-034 With ICACHE_EN: every ack in REQ or DROP fills the line, including flushed/discarded fetches.
REQ-035 Without ICACHE_EN: no cache storage; every accept is a miss.

Structure
REQ-036 Enable/Disable, True/False, AddrBus, InstBus, PcWidth and the state encodings live in the shared defines header.
REQ-037 Cache array/tag compare is one sub-module, ifetch_icache, instantiated only under ICACHE_EN.

Verification
REQ-038 Reset, then pc=0x0 valid, ack after 3 cycles with 0x00000013 -> o_MEM_req cycles 1-3; HOLD pc=0x0 inst=0x00000013.
REQ-039 Hold i_IDSUE_stall=1 for 4 cycles in HOLD -> outputs stable, o_PCREG_wait=1; release -> next pc 0x4 accepted same edge.
REQ-040 Flush during REQ for pc=0x8, ack 2 cycles later -> state DROP then IDLE, o_IDSUE_valid never asserted.
REQ-041 ICACHE_EN: fetch 0x10 twice -> second hits, o_MEM_req stays 0, HOLD 1 cycle after accept.
REQ-042 ICACHE_EN: 0x10 then 0x30 (same index, 8 lines) -> second misses and evicts the 0x10 line.
REQ-043 Assert rst mid-REQ, ack arrives after release -> o_IDSUE_valid stays 0, state IDLE.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch front-end: bus widths,
// boolean aliases, FSM state encoding and a parameter sanity helper.
package ifetch_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;

    localparam int ADDR_BUS = 32;
    localparam int INST_BUS = 32;
    localparam int PC_WIDTH = ADDR_BUS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ifetch_icache.sv
// Direct-mapped instruction cache, one word per line. Only built when
// ICACHE_EN is defined; index = pc[log2(LINES)+1:2], tag = remaining upper bits.
`ifdef ICACHE_EN
module ifetch_icache
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int LINES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic [INST_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_pc,
    input  logic [INST_W-1:0] fill_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [INST_W-1:0] data_mem [LINES];

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [TAG_W-1:0] fill_tag;
    logic             unused_ok;

    // Byte offset bits never take part in the lookup.
    assign unused_ok  = ^{lookup_pc[1:0], fill_pc[1:0]};

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign lookup_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign fill_idx   = fill_pc[IDX_W+1:2];
    assign fill_tag   = fill_pc[ADDR_W-1:IDX_W+2];

    assign hit      = line_valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign hit_data = data_mem[lookup_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[fill_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_data;
        end
    end

endmodule
`endif

// File: rtl/ifetch.sv
// Single-outstanding instruction fetch stage between PC register, instruction
// memory and issue. Define ICACHE_EN to add the direct-mapped ifetch_icache.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing held, ready to accept a PC
// REQ     | miss outstanding, o_MEM_req/o_MEM_addr held until ack
// HOLD    | instruction presented to issue (o_IDSUE_valid)
// DROP    | miss flushed, still waiting for its ack which is discarded
module ifetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_W       = ADDR_BUS,
    parameter int INST_W       = INST_BUS,
    parameter int ICACHE_LINES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_PCREG_pc,
    input  logic              i_PCREG_valid,
    output logic              o_PCREG_wait,
    output logic              o_MEM_req,
    output logic [ADDR_W-1:0] o_MEM_addr,
    input  logic              i_MEM_ack,
    input  logic [INST_W-1:0] i_MEM_data,
    output logic [INST_W-1:0] o_IDSUE_inst,
    output logic [ADDR_W-1:0] o_IDSUE_pc,
    output logic              o_IDSUE_valid,
    input  logic              i_IDSUE_stall,
    input  logic              i_ROB_flush
);

    if (!is_pow2(ICACHE_LINES) || ICACHE_LINES < 2) begin : g_bad_lines
        $error("ifetch: ICACHE_LINES must be a power of two, at least 2");
    end

    state_t            state;
    state_t            state_nxt;
    state_t            accept_target;
    logic              accept;
    logic              cache_hit;
    logic [INST_W-1:0] cache_data;
    logic              ack_forward;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] idsue_pc_q;
    logic [INST_W-1:0] idsue_inst_q;

`ifdef ICACHE_EN
    logic fill_en;

    // Every ack fills the line, even for flushed fetches: the word is still correct.
    assign fill_en = i_MEM_ack && ((state == ST_REQ) || (state == ST_DROP));

    ifetch_icache #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .LINES  (ICACHE_LINES)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .lookup_pc (i_PCREG_pc),
        .hit       (cache_hit),
        .hit_data  (cache_data),
        .fill_en   (fill_en),
        .fill_pc   (mem_addr_q),
        .fill_data (i_MEM_data)
    );
`else
    assign cache_hit  = FALSE;
    assign cache_data = '0;
`endif

    assign accept        = i_PCREG_valid && !o_PCREG_wait && !i_ROB_flush;
    assign accept_target = cache_hit ? ST_HOLD : ST_REQ;
    assign ack_forward   = (state == ST_REQ) && i_MEM_ack && !i_ROB_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = accept_target;
                end
            end
            ST_REQ: begin
                if (i_MEM_ack) begin
                    state_nxt = i_ROB_flush ? ST_IDLE : ST_HOLD;
                end else if (i_ROB_flush) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (i_ROB_flush) begin
                    state_nxt = ST_IDLE;
                end else if (!i_IDSUE_stall) begin
                    state_nxt = accept ? accept_target : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (i_MEM_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_PCREG_wait  = FALSE;
        o_MEM_req     = FALSE;
        o_IDSUE_valid = FALSE;
        unique case (state)
            ST_REQ, ST_DROP: begin
                o_PCREG_wait = TRUE;
                o_MEM_req    = TRUE;
            end
            ST_HOLD: begin
                o_IDSUE_valid = TRUE;
                o_PCREG_wait  = i_IDSUE_stall;
            end
            default: ;
        endcase
    end

    // mem_addr_q doubles as the captured PC of the outstanding miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q   <= '0;
            idsue_pc_q   <= '0;
            idsue_inst_q <= '0;
        end else if (accept) begin
            mem_addr_q <= i_PCREG_pc;
            if (cache_hit) begin
                idsue_pc_q   <= i_PCREG_pc;
                idsue_inst_q <= cache_data;
            end
        end else if (ack_forward) begin
            idsue_pc_q   <= mem_addr_q;
            idsue_inst_q <= i_MEM_data;
        end
    end

    assign o_MEM_addr   = mem_addr_q;
    assign o_IDSUE_pc   = idsue_pc_q;
    assign o_IDSUE_inst = idsue_inst_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: behavioural fetch model compared every
// cycle plus directed sequences with literal expectations.
module tb_ifetch;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int LINES = 8;
`ifdef ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc;
    logic          pcv;
    logic          ack;
    logic [IW-1:0] mdata;
    logic          stall;
    logic          flush;
    logic          o_PCREG_wait;
    logic          o_MEM_req;
    logic [AW-1:0] o_MEM_addr;
    logic [IW-1:0] o_IDSUE_inst;
    logic [AW-1:0] o_IDSUE_pc;
    logic          o_IDSUE_valid;

    ifetch #(.ADDR_W(AW), .INST_W(IW), .ICACHE_LINES(LINES)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_PCREG_pc    (pc),
        .i_PCREG_valid (pcv),
        .o_PCREG_wait  (o_PCREG_wait),
        .o_MEM_req     (o_MEM_req),
        .o_MEM_addr    (o_MEM_addr),
        .i_MEM_ack     (ack),
        .i_MEM_data    (mdata),
        .o_IDSUE_inst  (o_IDSUE_inst),
        .o_IDSUE_pc    (o_IDSUE_pc),
        .o_IDSUE_valid (o_IDSUE_valid),
        .i_IDSUE_stall (stall),
        .i_ROB_flush   (flush)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: at most one pending memory fetch, at most one presented word.
    logic          m_pend, m_drop, m_pres;
    logic [AW-1:0] m_pend_pc, m_pres_pc;
    logic [IW-1:0] m_pres_inst;
    logic          c_val [LINES];
    logic [AW-1:0] c_pc  [LINES];
    logic [IW-1:0] c_dat [LINES];
    logic          m_busy, m_take, m_hit;
    int            m_idx, f_idx;

    always_comb begin
        m_busy = m_pend || (m_pres && stall);
        m_take = pcv && !m_busy && !flush;
        m_idx  = int'((pc >> 2) % LINES);
        f_idx  = int'((m_pend_pc >> 2) % LINES);
        m_hit  = CACHE_ON && c_val[m_idx] && (c_pc[m_idx] == {pc[AW-1:2], 2'b00});
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend      <= 1'b0;
            m_drop      <= 1'b0;
            m_pres      <= 1'b0;
            m_pend_pc   <= '0;
            m_pres_pc   <= '0;
            m_pres_inst <= '0;
            for (int i = 0; i < LINES; i++) c_val[i] <= 1'b0;
        end else begin
            if (m_pend && ack) begin
                m_pend <= 1'b0;
                if (CACHE_ON) begin
                    c_val[f_idx] <= 1'b1;
                    c_pc[f_idx]  <= {m_pend_pc[AW-1:2], 2'b00};
                    c_dat[f_idx] <= mdata;
                end
                if (!m_drop && !flush) begin
                    m_pres      <= 1'b1;
                    m_pres_pc   <= m_pend_pc;
                    m_pres_inst <= mdata;
                end
            end else if (m_pend && flush) begin
                m_drop <= 1'b1;
            end
            if (m_pres && (flush || !stall)) m_pres <= 1'b0;
            if (m_take) begin
                if (m_hit) begin
                    m_pres      <= 1'b1;
                    m_pres_pc   <= pc;
                    m_pres_inst <= c_dat[m_idx];
                end else begin
                    m_pend    <= 1'b1;
                    m_pend_pc <= pc;
                    m_drop    <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_valid", o_IDSUE_valid, m_pres);
            chk("model_mem_req", o_MEM_req, m_pend);
            chk("model_wait", o_PCREG_wait, m_busy);
            if (m_pend) chk("model_mem_addr", o_MEM_addr, m_pend_pc);
            if (m_pres) begin
                chk("model_idsue_pc", o_IDSUE_pc, m_pres_pc);
                chk("model_idsue_inst", o_IDSUE_inst, m_pres_inst);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete a miss with immediate ack, then let issue consume it.
    task automatic miss_fetch(input logic [AW-1:0] a, input logic [IW-1:0] d);
        pc = a; pcv = 1'b1;
        tick();
        pcv = 1'b0;
        chk("miss_req", o_MEM_req, 1);
        ack = 1'b1; mdata = d;
        tick();
        ack = 1'b0;
        chk("miss_hold_inst", o_IDSUE_inst, d);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        pc = '0; pcv = 1'b0; ack = 1'b0; mdata = '0; stall = 1'b0; flush = 1'b0;
        #1;
        chk("rst_valid", o_IDSUE_valid, 0);
        chk("rst_req", o_MEM_req, 0);
        chk("rst_addr", o_MEM_addr, 0);
        chk("rst_pc", o_IDSUE_pc, 0);
        chk("rst_inst", o_IDSUE_inst, 0);
        tick(); tick();
        rst = 1'b0;

        // pc 0x0 miss, ack in third request cycle
        pc = 32'h0; pcv = 1'b1;
        tick();
        pcv = 1'b0;
        chk("f0_req_c1", o_MEM_req, 1);
        chk("f0_addr", o_MEM_addr, 32'h0);
        tick();
        chk("f0_req_c2", o_MEM_req, 1);
        tick();
        chk("f0_req_c3", o_MEM_req, 1);
        ack = 1'b1; mdata = 32'h0000_0013;
        tick();
        ack = 1'b0; mdata = '0;
        chk("f0_valid", o_IDSUE_valid, 1);
        chk("f0_pc", o_IDSUE_pc, 32'h0);
        chk("f0_inst", o_IDSUE_inst, 32'h0000_0013);
        chk("f0_req_drop", o_MEM_req, 0);

        // issue stall for 4 cycles while next PC waits
        stall = 1'b1; pc = 32'h4; pcv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_wait", o_PCREG_wait, 1);
            chk("stall_valid", o_IDSUE_valid, 1);
            chk("stall_inst", o_IDSUE_inst, 32'h0000_0013);
            chk("stall_pc", o_IDSUE_pc, 32'h0);
            tick();
        end
        stall = 1'b0;
        tick();
        pcv = 1'b0;
        chk("b2b_req", o_MEM_req, 1);
        chk("b2b_addr", o_MEM_addr, 32'h4);
        chk("b2b_valid", o_IDSUE_valid, 0);
        ack = 1'b1; mdata = 32'h0010_0093;
        tick();
        ack = 1'b0;
        chk("f4_pc", o_IDSUE_pc, 32'h4);
        chk("f4_inst", o_IDSUE_inst, 32'h0010_0093);
        tick();
        chk("f4_consumed", o_IDSUE_valid, 0);

        // flush during miss for 0x8, ack two cycles later
        pc = 32'h8; pcv = 1'b1;
        tick();
        pcv = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drop_req", o_MEM_req, 1);
        chk("drop_wait", o_PCREG_wait, 1);
        chk("drop_valid", o_IDSUE_valid, 0);
        tick();
        ack = 1'b1; mdata = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        chk("drop_idle_req", o_MEM_req, 0);
        chk("drop_idle_valid", o_IDSUE_valid, 0);
        chk("drop_idle_wait", o_PCREG_wait, 0);

        // flush and ack in the same REQ cycle
        pc = 32'hC; pcv = 1'b1;
        tick();
        pcv = 1'b0; flush = 1'b1; ack = 1'b1; mdata = 32'h1111_1111;
        tick();
        flush = 1'b0; ack = 1'b0;
        chk("flack_valid", o_IDSUE_valid, 0);
        chk("flack_req", o_MEM_req, 0);

        // flush in HOLD beats a simultaneous accept
        pc = 32'h20; pcv = 1'b1;
        tick();
        pcv = 1'b0; ack = 1'b1; mdata = 32'h2222_2222;
        tick();
        ack = 1'b0;
        chk("f20_valid", o_IDSUE_valid, 1);
        flush = 1'b1; pc = 32'h24; pcv = 1'b1;
        tick();
        flush = 1'b0; pcv = 1'b0;
        chk("hflush_valid", o_IDSUE_valid, 0);
        chk("hflush_req", o_MEM_req, 0);

        // stray ack in IDLE
        ack = 1'b1; mdata = 32'h5555_5555;
        tick();
        ack = 1'b0;
        chk("idle_ack_valid", o_IDSUE_valid, 0);

        // stray ack in HOLD must not disturb the presented word
        pc = 32'h18; pcv = 1'b1;
        tick();
        pcv = 1'b0; ack = 1'b1; mdata = 32'h1818_1818;
        tick();
        stall = 1'b1; mdata = 32'h9999_9999;
        tick();
        ack = 1'b0;
        chk("hold_ack_inst", o_IDSUE_inst, 32'h1818_1818);
        chk("hold_ack_valid", o_IDSUE_valid, 1);
        stall = 1'b0;
        tick();

`ifdef ICACHE_EN
        // 0x8 line was filled by the discarded ack
        pc = 32'h8; pcv = 1'b1;
        tick();
        pcv = 1'b0;
        chk("c8_hit_req", o_MEM_req, 0);
        chk("c8_hit_valid", o_IDSUE_valid, 1);
        chk("c8_hit_inst", o_IDSUE_inst, 32'hDEAD_BEEF);
        tick();
        miss_fetch(32'h10, 32'hAAAA_0010);
        pc = 32'h10; pcv = 1'b1;
        #1;
        chk("c10_hit_noreq", o_MEM_req, 0);
        tick();
        pcv = 1'b0;
        chk("c10_hit_valid", o_IDSUE_valid, 1);
        chk("c10_hit_req", o_MEM_req, 0);
        chk("c10_hit_inst", o_IDSUE_inst, 32'hAAAA_0010);
        tick();
        miss_fetch(32'h30, 32'hBBBB_0030);
        pc = 32'h10; pcv = 1'b1;
        tick();
        pcv = 1'b0;
        chk("c10_evicted_req", o_MEM_req, 1);
        ack = 1'b1; mdata = 32'hAAAA_0010;
        tick();
        ack = 1'b0;
        tick();
`else
        miss_fetch(32'h10, 32'hAAAA_0010);
        pc = 32'h10; pcv = 1'b1;
        tick();
        pcv = 1'b0;
        chk("nocache_refetch_req", o_MEM_req, 1);
        ack = 1'b1; mdata = 32'hAAAA_0010;
        tick();
        ack = 1'b0;
        tick();
`endif

        // async reset mid-miss, late ack after release
        pc = 32'h40; pcv = 1'b1;
        tick();
        pcv = 1'b0;
        chk("r40_req", o_MEM_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", o_MEM_req, 0);
        chk("arst_valid", o_IDSUE_valid, 0);
        chk("arst_addr", o_MEM_addr, 0);
        chk("arst_pc", o_IDSUE_pc, 0);
        chk("arst_inst", o_IDSUE_inst, 0);
        tick();
        rst = 1'b0;
        ack = 1'b1; mdata = 32'h4040_4040;
        tick();
        ack = 1'b0;
        chk("late_ack_valid", o_IDSUE_valid, 0);
        chk("late_ack_req", o_MEM_req, 0);
        tick();
        chk("late_ack_valid2", o_IDSUE_valid, 0);

        // cache contents do not survive reset
        pc = 32'h10; pcv = 1'b1;
        tick();
        pcv = 1'b0;
        chk("post_rst_miss", o_MEM_req, 1);
        ack = 1'b1; mdata = 32'h7777_0010;
        tick();
        ack = 1'b0;
        chk("post_rst_inst", o_IDSUE_inst, 32'h7777_0010);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
